painterengine_gpu_blit_addrgen: RTL and testbench

//  Pixel address generator directly downstream of the GPU clip stage. Takes one clipped blit
//  (dest x/y, source clip rectangle, mirror mode) and emits one (src_addr, dst_addr) pair per

---
 rtl/painterengine_gpu_blit_addrgen_if.sv | 47 ++++
 rtl/painterengine_gpu_blit_addrgen.sv | 155 +++++++++++++++
 tb/tb_painterengine_gpu_blit_addrgen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_blit_addrgen_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | painterengine_gpu_blit_addrgen_if                                          |
// | Blit setup and address-pair stream bundle between clip stage and R/W engine|
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
interface painterengine_gpu_blit_addrgen_if #(
   parameter int PARAM_TEXTURE_MAX_SIZE = 16,
   parameter int PARAM_ADDRESS_WIDTH    = 32
);
   logic                              i_wire_start;
   logic [PARAM_ADDRESS_WIDTH-1:0]    i_wire_src_base;
   logic [PARAM_ADDRESS_WIDTH-1:0]    i_wire_dst_base;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_src_width;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_dst_width;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_x;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_y;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipx;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipy;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_clipw;
   logic [PARAM_TEXTURE_MAX_SIZE-1:0] i_wire_cliph;
   logic [2:0]                        i_wire_mirror_mode;
   logic [PARAM_ADDRESS_WIDTH-1:0]    o_wire_src_addr;
   logic [PARAM_ADDRESS_WIDTH-1:0]    o_wire_dst_addr;
   logic                              o_wire_valid;
   logic                              i_wire_ready;
   logic                              o_wire_last;
   logic                              o_wire_busy;
   logic                              o_wire_done;

   modport slave (
      input  i_wire_start, i_wire_src_base, i_wire_dst_base, i_wire_src_width,
             i_wire_dst_width, i_wire_x, i_wire_y, i_wire_clipx, i_wire_clipy,
             i_wire_clipw, i_wire_cliph, i_wire_mirror_mode, i_wire_ready,
      output o_wire_src_addr, o_wire_dst_addr, o_wire_valid, o_wire_last,
             o_wire_busy, o_wire_done
   );

   modport master (
      output i_wire_start, i_wire_src_base, i_wire_dst_base, i_wire_src_width,
             i_wire_dst_width, i_wire_x, i_wire_y, i_wire_clipx, i_wire_clipy,
             i_wire_clipw, i_wire_cliph, i_wire_mirror_mode, i_wire_ready,
      input  o_wire_src_addr, o_wire_dst_addr, o_wire_valid, o_wire_last,
             o_wire_busy, o_wire_done
   );
endinterface
`default_nettype wire

// File: rtl/painterengine_gpu_blit_addrgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | painterengine_gpu_blit_addrgen                                             |
// | Per-pixel source/destination address generator for one clipped blit        |
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module painterengine_gpu_blit_addrgen #(
   parameter int PARAM_TEXTURE_MAX_SIZE = 16,
   parameter int PARAM_ADDRESS_WIDTH    = 32,
   parameter int PARAM_BPP_SHIFT        = 2
) (
   input wire logic                       i_wire_clock,
   input wire logic                       i_wire_reset,
   painterengine_gpu_blit_addrgen_if.slave bus
);
   localparam int TS = PARAM_TEXTURE_MAX_SIZE;
   localparam int AW = PARAM_ADDRESS_WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef struct packed {
      logic [AW-1:0] src_base;
      logic [AW-1:0] dst_base;
      logic [TS-1:0] src_width;
      logic [TS-1:0] dst_width;
      logic [TS-1:0] x;
      logic [TS-1:0] y;
      logic [TS-1:0] clipx;
      logic [TS-1:0] clipy;
      logic [TS-1:0] clipw;
      logic [TS-1:0] cliph;
      logic [2:0]    mode;
   } cfg_t;

   logic [1:0]    state_q,   state_d;
   cfg_t          cfg_q,     cfg_d;
   logic [TS-1:0] col_q,     col_d;
   logic [TS-1:0] row_q,     row_d;
   logic [AW-1:0] src_row_q, src_row_d;
   logic [AW-1:0] src_pix_q, src_pix_d;
   logic [AW-1:0] dst_row_q, dst_row_d;
   logic [AW-1:0] dst_pix_q, dst_pix_d;

   logic          w_h, w_v, w_empty, w_col_end, w_row_end, w_valid, w_last;
   logic [AW-1:0] w_srow, w_scol, w_src_first, w_dst_first;
   logic [AW-1:0] w_pix_step, w_src_stride, w_dst_stride, w_src_next_row, w_dst_next_row;

   // Mode codes above 3 never reach RUN, so bits [1:0] fully describe mirroring there.
   assign w_h     = cfg_q.mode[0];
   assign w_v     = cfg_q.mode[1];
   assign w_empty = (cfg_q.clipw == '0) || (cfg_q.cliph == '0) || (cfg_q.mode > 3'd3);

   assign w_srow      = AW'(cfg_q.clipy) + (w_v ? AW'(cfg_q.cliph) - AW'(1) : '0);
   assign w_scol      = AW'(cfg_q.clipx) + (w_h ? AW'(cfg_q.clipw) - AW'(1) : '0);
   assign w_src_first = cfg_q.src_base
                      + ((w_srow * AW'(cfg_q.src_width) + w_scol) << PARAM_BPP_SHIFT);
   assign w_dst_first = cfg_q.dst_base
                      + ((AW'(cfg_q.y) * AW'(cfg_q.dst_width) + AW'(cfg_q.x)) << PARAM_BPP_SHIFT);

   assign w_pix_step     = AW'(1) << PARAM_BPP_SHIFT;
   assign w_src_stride   = AW'(cfg_q.src_width) << PARAM_BPP_SHIFT;
   assign w_dst_stride   = AW'(cfg_q.dst_width) << PARAM_BPP_SHIFT;
   assign w_src_next_row = w_v ? src_row_q - w_src_stride : src_row_q + w_src_stride;
   assign w_dst_next_row = dst_row_q + w_dst_stride;

   assign w_col_end = (col_q == cfg_q.clipw - TS'(1));
   assign w_row_end = (row_q == cfg_q.cliph - TS'(1));
   assign w_valid   = (state_q == ST_RUN);
   assign w_last    = w_valid && w_col_end && w_row_end;

   always_comb begin
      state_d   = state_q;
      cfg_d     = cfg_q;
      col_d     = col_q;
      row_d     = row_q;
      src_row_d = src_row_q;
      src_pix_d = src_pix_q;
      dst_row_d = dst_row_q;
      dst_pix_d = dst_pix_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.i_wire_start) begin
               state_d = ST_LOAD;
               cfg_d   = '{src_base:  bus.i_wire_src_base,  dst_base:  bus.i_wire_dst_base,
                           src_width: bus.i_wire_src_width, dst_width: bus.i_wire_dst_width,
                           x:         bus.i_wire_x,         y:         bus.i_wire_y,
                           clipx:     bus.i_wire_clipx,     clipy:     bus.i_wire_clipy,
                           clipw:     bus.i_wire_clipw,     cliph:     bus.i_wire_cliph,
                           mode:      bus.i_wire_mirror_mode};
            end
         end
         ST_LOAD: begin
            col_d     = '0;
            row_d     = '0;
            src_row_d = w_src_first;
            src_pix_d = w_src_first;
            dst_row_d = w_dst_first;
            dst_pix_d = w_dst_first;
            state_d   = w_empty ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (bus.i_wire_ready) begin
               if (w_last) begin
                  state_d = ST_DONE;
               end else if (!w_col_end) begin
                  col_d     = col_q + TS'(1);
                  dst_pix_d = dst_pix_q + w_pix_step;
                  src_pix_d = w_h ? src_pix_q - w_pix_step : src_pix_q + w_pix_step;
               end else begin
                  col_d     = '0;
                  row_d     = row_q + TS'(1);
                  src_row_d = w_src_next_row;
                  src_pix_d = w_src_next_row;
                  dst_row_d = w_dst_next_row;
                  dst_pix_d = w_dst_next_row;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
      if (i_wire_reset) begin
         state_q   <= ST_IDLE;
         cfg_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         src_row_q <= '0;
         src_pix_q <= '0;
         dst_row_q <= '0;
         dst_pix_q <= '0;
      end else begin
         state_q   <= state_d;
         cfg_q     <= cfg_d;
         col_q     <= col_d;
         row_q     <= row_d;
         src_row_q <= src_row_d;
         src_pix_q <= src_pix_d;
         dst_row_q <= dst_row_d;
         dst_pix_q <= dst_pix_d;
      end
   end

   assign bus.o_wire_src_addr = src_pix_q;
   assign bus.o_wire_dst_addr = dst_pix_q;
   assign bus.o_wire_valid    = w_valid;
   assign bus.o_wire_last     = w_last;
   assign bus.o_wire_busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
   assign bus.o_wire_done     = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_blit_addrgen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_painterengine_gpu_blit_addrgen                                          |
// | Vector table of blits plus reset/start corner sequences, scoreboard-checked|
// | Rev 1.0  initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_painterengine_gpu_blit_addrgen;
   localparam int TS = 16;
   localparam int AW = 32;

   typedef struct {
      logic [31:0] sb, db;
      logic [15:0] sw, dw, x, y, cx, cy, cw, ch;
      logic [2:0]  mode;
      int          bp;
      bit          poke;
      int          exp_n;
      logic [31:0] exp_s0, exp_d0;
   } vec_t;

   typedef struct {
      logic [31:0] src, dst;
      logic        last;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   int     tests = 0;
   int     fails = 0;
   exp_t   sbq[$];
   vec_t   vecs[11];

   always #5 clk = ~clk;

   painterengine_gpu_blit_addrgen_if #(.PARAM_TEXTURE_MAX_SIZE(TS), .PARAM_ADDRESS_WIDTH(AW)) bus();

   painterengine_gpu_blit_addrgen #(
      .PARAM_TEXTURE_MAX_SIZE(TS), .PARAM_ADDRESS_WIDTH(AW), .PARAM_BPP_SHIFT(2)
   ) dut (
      .i_wire_clock(clk),
      .i_wire_reset(rst),
      .bus(bus.slave)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] sb, db, input logic [15:0] sw, dw, x, y,
                               cx, cy, cw, ch, input logic [2:0] m, input int bp,
                               input bit poke, input int n, input logic [31:0] s0, d0);
      vec_t v;
      v.sb = sb; v.db = db; v.sw = sw; v.dw = dw; v.x = x; v.y = y;
      v.cx = cx; v.cy = cy; v.cw = cw; v.ch = ch; v.mode = m;
      v.bp = bp; v.poke = poke; v.exp_n = n; v.exp_s0 = s0; v.exp_d0 = d0;
      return v;
   endfunction

   function automatic logic rdy(input int bp, input int i);
      return (bp == 0) ? 1'b1 : ((i % 3) == 0);
   endfunction

   task automatic apply_cfg(input vec_t v);
      bus.i_wire_src_base = v.sb;  bus.i_wire_dst_base = v.db;
      bus.i_wire_src_width = v.sw; bus.i_wire_dst_width = v.dw;
      bus.i_wire_x = v.x;          bus.i_wire_y = v.y;
      bus.i_wire_clipx = v.cx;     bus.i_wire_clipy = v.cy;
      bus.i_wire_clipw = v.cw;     bus.i_wire_cliph = v.ch;
      bus.i_wire_mirror_mode = v.mode;
   endtask

   // Reference addresses come straight from pixel coordinates, not incremental stepping.
   task automatic push_model(input vec_t v);
      exp_t e;
      logic [31:0] sr, sc;
      if (v.cw == 0 || v.ch == 0 || v.mode > 3) return;
      for (int r = 0; r < int'(v.ch); r++) begin
         for (int c = 0; c < int'(v.cw); c++) begin
            sr = 32'(v.cy) + (v.mode[1] ? 32'(v.ch) - 32'd1 - 32'(r) : 32'(r));
            sc = 32'(v.cx) + (v.mode[0] ? 32'(v.cw) - 32'd1 - 32'(c) : 32'(c));
            e.src  = v.sb + ((sr * 32'(v.sw) + sc) << 2);
            e.dst  = v.db + (((32'(v.y) + 32'(r)) * 32'(v.dw) + 32'(v.x) + 32'(c)) << 2);
            e.last = (r == int'(v.ch) - 1) && (c == int'(v.cw) - 1);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic run_blit(input vec_t v, input string nm);
      int   n_acc, first_valid, last_idx;
      bit   done_seen;
      exp_t e;
      apply_cfg(v);
      bus.i_wire_start = 1'b1;
      bus.i_wire_ready = 1'b1;
      push_model(v);
      @(posedge clk); #1;
      bus.i_wire_start = 1'b0;
      bus.i_wire_ready = rdy(v.bp, 0);
      n_acc = 0; first_valid = -1; last_idx = -1; done_seen = 1'b0;
      for (int idx = 0; idx < 200 && !done_seen; idx++) begin
         @(negedge clk);
         if (idx == 0) chk({nm, "_busy_load"}, bus.o_wire_busy, 1'b1);
         if (bus.o_wire_done) begin
            done_seen = 1'b1;
            chk({nm, "_done_latency"}, idx, (last_idx < 0) ? 1 : last_idx + 1);
         end else if (bus.o_wire_valid) begin
            if (first_valid < 0) begin
               first_valid = idx;
               chk({nm, "_first_valid_latency"}, idx, 1);
               chk({nm, "_first_src"}, bus.o_wire_src_addr, v.exp_s0);
               chk({nm, "_first_dst"}, bus.o_wire_dst_addr, v.exp_d0);
            end
            if (sbq.size() == 0) begin
               chk({nm, "_unexpected_pair"}, bus.o_wire_src_addr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sbq[0];
               chk({nm, "_src"}, bus.o_wire_src_addr, e.src);
               chk({nm, "_dst"}, bus.o_wire_dst_addr, e.dst);
               chk({nm, "_last"}, bus.o_wire_last, e.last);
               if (bus.i_wire_ready) begin
                  void'(sbq.pop_front());
                  n_acc++;
                  if (e.last) last_idx = idx;
               end
            end
         end
         if (!done_seen) begin
            @(posedge clk); #1;
            if (v.poke && idx == 2) begin
               bus.i_wire_start = 1'b1;
               bus.i_wire_clipx = 16'd7;
               bus.i_wire_mirror_mode = 3'd1;
            end else if (v.poke && idx == 3) begin
               bus.i_wire_start = 1'b0;
               apply_cfg(v);
            end
            bus.i_wire_ready = rdy(v.bp, idx + 1);
         end
      end
      chk({nm, "_done_seen"}, done_seen, 1'b1);
      chk({nm, "_pair_count"}, n_acc, v.exp_n);
      chk({nm, "_leftover"}, sbq.size(), 0);
      chk({nm, "_busy_in_done"}, bus.o_wire_busy, 1'b0);
      chk({nm, "_valid_in_done"}, bus.o_wire_valid, 1'b0);
      sbq.delete();
   endtask

   initial begin
      int n;
      vecs[0]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd0, 0, 0, 6, 32'h1028, 32'h80D0);
      vecs[1]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd3, 0, 0, 6, 32'h1050, 32'h80D0);
      vecs[2]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd0, 1, 0, 6, 32'h1028, 32'h80D0);
      vecs[3]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd1, 1, 0, 6, 32'h1030, 32'h80D0);
      vecs[4]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd2, 0, 0, 6, 32'h1048, 32'h80D0);
      vecs[5]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 0, 2, 3'd0, 0, 0, 0, 32'h0,    32'h0);
      vecs[6]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd5, 0, 0, 0, 32'h0,    32'h0);
      vecs[7]  = mk(32'h2000, 32'h0,    4, 4,  1, 1, 0, 0, 1, 1, 3'd0, 0, 0, 1, 32'h2000, 32'h14);
      vecs[8]  = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 2, 3'd0, 0, 1, 6, 32'h1028, 32'h80D0);
      vecs[9]  = mk(32'h1000, 32'h8000, 10, 16, 0, 0, 5, 3, 4, 3, 3'd3, 1, 0, 12, 32'h10E8, 32'h8000);
      vecs[10] = mk(32'h1000, 32'h8000, 8, 16, 4, 3, 2, 1, 3, 0, 3'd0, 0, 0, 0, 32'h0,    32'h0);

      bus.i_wire_start = 1'b0;
      bus.i_wire_ready = 1'b0;
      apply_cfg(vecs[0]);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", bus.o_wire_valid, 1'b0);
      chk("reset_busy", bus.o_wire_busy, 1'b0);
      chk("reset_done", bus.o_wire_done, 1'b0);
      chk("reset_last", bus.o_wire_last, 1'b0);
      chk("reset_src", bus.o_wire_src_addr, 32'h0);
      chk("reset_dst", bus.o_wire_dst_addr, 32'h0);

      // start held across an edge while reset is asserted must be lost
      bus.i_wire_start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.i_wire_start = 1'b0;
      @(negedge clk);
      chk("rst_wins_busy", bus.o_wire_busy, 1'b0);
      @(negedge clk);
      chk("rst_wins_valid", bus.o_wire_valid, 1'b0);

      for (int i = 0; i < 11; i++) run_blit(vecs[i], $sformatf("vec%0d", i));

      // abort after three accepted pairs
      apply_cfg(vecs[0]);
      bus.i_wire_ready = 1'b1;
      bus.i_wire_start = 1'b1;
      @(posedge clk); #1;
      bus.i_wire_start = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         @(negedge clk);
         if (bus.o_wire_valid && bus.i_wire_ready) n++;
      end
      chk("abort_pairs_before_reset", n, 3);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_valid", bus.o_wire_valid, 1'b0);
      chk("abort_busy", bus.o_wire_busy, 1'b0);
      chk("abort_done", bus.o_wire_done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_no_resume_busy", bus.o_wire_busy, 1'b0);
      chk("abort_no_resume_valid", bus.o_wire_valid, 1'b0);
      run_blit(vecs[0], "post_abort");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
